dec2stch_array: RTL and testbench

//  Multi-channel decimal-to-stochastic converter with an internal LFSR and framed, double-buffered loads.

---
 rtl/dec2stch_array.sv | 155 +++++++++++++++
 tb/tb_dec2stch_array.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dec2stch_array.sv
// Multi-channel decimal-to-stochastic converter: one shared LFSR, one rotated view per channel,
// fixed-length frames with a shadow register so back-to-back loads run without gap cycles.
module dec2stch_array #(
    parameter int             ND   = 8,
    parameter int             NCH  = 4,
    parameter logic [ND-1:0]  SEED = ND'(1)
) (
    input  logic              CLK,
    input  logic              INIT,
    input  logic [NCH*ND-1:0] D_IN,
    input  logic              LOAD_VALID,
    output logic              LOAD_READY,
    input  logic              STOP,
    output logic [NCH-1:0]    S,
    output logic              S_VALID,
    output logic              FRAME_DONE,
    output logic              BUSY
);

    // Tap masks for maximal-length polynomials; bit (t-1) set for tap t.
    function automatic logic [ND-1:0] tap_mask(input int n);
        logic [15:0] m;
        case (n)
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0829;
            13:      m = 16'h100D;
            14:      m = 16'h2015;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h00B8;
        endcase
        return m[ND-1:0];
    endfunction

    function automatic logic [ND-1:0] rotl(input logic [ND-1:0] v, input int r);
        logic [ND-1:0] o;
        o = '0;
        for (int i = 0; i < ND; i++) begin
            o[(i + r) % ND] = v[i];
        end
        return o;
    endfunction

    localparam logic [ND-1:0] TAPS     = tap_mask(ND);
    localparam logic [ND-1:0] LAST_CNT = ND'((1 << ND) - 2);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              state_q;
    logic [NCH*ND-1:0]   d_act_q;
    logic [NCH*ND-1:0]   shadow_q;
    logic                shadow_full_q;
    logic [ND-1:0]       lfsr_q;
    logic [ND-1:0]       lfsr_d;
    logic [ND-1:0]       cnt_q;
    logic [NCH-1:0]      s_q;
    logic [NCH-1:0]      s_d;
    logic                s_valid_q;
    logic                frame_done_q;
    logic                accept;
    logic                last;

    // Handshake: a load is taken on any rising edge where LOAD_VALID and LOAD_READY are both
    // high; LOAD_READY depends only on the shadow register, never on LOAD_VALID.
    assign LOAD_READY = !shadow_full_q;
    assign accept     = LOAD_VALID && LOAD_READY;
    assign last       = (cnt_q == LAST_CNT);

    assign S          = s_q;
    assign S_VALID    = s_valid_q;
    assign FRAME_DONE = frame_done_q;
    assign BUSY       = (state_q == RUN);

    always_comb begin
        lfsr_d = {lfsr_q[ND-2:0], ^(lfsr_q & TAPS)};
        if (lfsr_q == '0) begin
            lfsr_d = SEED;
        end
    end

    // Rotating the shared LFSR per channel keeps each channel's threshold sequence a permutation
    // of 1..2^ND-1, so the ones count per frame stays exact while channels decorrelate.
    always_comb begin
        s_d = '0;
        for (int k = 0; k < NCH; k++) begin
            s_d[k] = (d_act_q[k*ND +: ND] >= rotl(lfsr_q, k % ND));
        end
    end

    always_ff @(posedge CLK or negedge INIT) begin
        if (!INIT) begin
            state_q       <= IDLE;
            d_act_q       <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            lfsr_q        <= SEED;
            cnt_q         <= '0;
            s_q           <= '0;
            s_valid_q     <= 1'b0;
            frame_done_q  <= 1'b0;
        end else if (STOP) begin
            state_q       <= IDLE;
            shadow_full_q <= 1'b0;
            lfsr_q        <= SEED;
            cnt_q         <= '0;
            s_q           <= '0;
            s_valid_q     <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    s_q          <= '0;
                    s_valid_q    <= 1'b0;
                    frame_done_q <= 1'b0;
                    if (accept) begin
                        d_act_q <= D_IN;
                        lfsr_q  <= SEED;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    s_q          <= s_d;
                    s_valid_q    <= 1'b1;
                    frame_done_q <= last;
                    lfsr_q       <= lfsr_d;
                    cnt_q        <= cnt_q + ND'(1);
                    if (last) begin
                        cnt_q <= '0;
                        if (shadow_full_q) begin
                            d_act_q       <= shadow_q;
                            shadow_full_q <= 1'b0;
                        end else if (accept) begin
                            // A load landing on the boundary goes straight to the active register.
                            d_act_q <= D_IN;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (accept) begin
                        shadow_q      <= D_IN;
                        shadow_full_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dec2stch_array.sv
// Directed bench for dec2stch_array: frame summaries (length + ones per channel) are queued at
// load time and compared by a negedge monitor whenever a frame ends.
module tb_dec2stch_array;

    localparam int ND  = 8;
    localparam int NCH = 4;
    localparam int W   = 16 * (NCH + 1);

    logic              CLK;
    logic              INIT;
    logic [NCH*ND-1:0] D_IN;
    logic              LOAD_VALID;
    logic              LOAD_READY;
    logic              STOP;
    logic [NCH-1:0]    S;
    logic              S_VALID;
    logic              FRAME_DONE;
    logic              BUSY;

    dec2stch_array #(.ND(ND), .NCH(NCH), .SEED(8'h01)) dut (
        .CLK        (CLK),
        .INIT       (INIT),
        .D_IN       (D_IN),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_READY (LOAD_READY),
        .STOP       (STOP),
        .S          (S),
        .S_VALID    (S_VALID),
        .FRAME_DONE (FRAME_DONE),
        .BUSY       (BUSY)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int pass_cnt    = 0;
    int total_cnt   = 0;
    int frames_seen = 0;
    logic abort_ok  = 1'b0;

    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Frame summary: {length, ones ch3, ones ch2, ones ch1, ones ch0}, 16 bits each.
    function automatic logic [W-1:0] frame_sum(input int c0, input int c1, input int c2, input int c3);
        return {16'(255), 16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    endfunction

    // monitor / scoreboard
    int ones [NCH];
    int len = 0;
    initial for (int k = 0; k < NCH; k++) ones[k] = 0;

    always @(negedge CLK) begin
        logic [W-1:0] act;
        if (S_VALID) begin
            len++;
            for (int k = 0; k < NCH; k++) if (S[k]) ones[k]++;
            if (FRAME_DONE) begin
                act = {16'(len), 16'(ones[3]), 16'(ones[2]), 16'(ones[1]), 16'(ones[0])};
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_frame: got %0h expected none", act);
                end else begin
                    check("frame", act, exp_q.pop_front());
                end
                frames_seen++;
                len = 0;
                for (int k = 0; k < NCH; k++) ones[k] = 0;
            end
        end else if (len != 0) begin
            if (!abort_ok) begin
                total_cnt++;
                $display("FAIL frame_gap: got gap after %0d bits expected 255", len);
            end
            len = 0;
            for (int k = 0; k < NCH; k++) ones[k] = 0;
        end
    end

    // driver tasks
    task automatic do_load(input logic [NCH*ND-1:0] d);
        int n;
        n = 0;
        @(negedge CLK);
        D_IN       = d;
        LOAD_VALID = 1'b1;
        while (!LOAD_READY && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 2000) begin
            total_cnt++;
            $display("FAIL load_timeout: got no LOAD_READY expected accept");
        end
        @(posedge CLK);
        #1;
        LOAD_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge CLK);
        while ((BUSY || S_VALID) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 2000) begin
            total_cnt++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
    endtask

    int base;

    initial begin
        INIT       = 1'b0;
        D_IN       = '0;
        LOAD_VALID = 1'b0;
        STOP       = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_s",       W'(S),          W'(0));
        check("rst_s_valid", W'(S_VALID),    W'(0));
        check("rst_ready",   W'(LOAD_READY), W'(1));
        check("rst_busy",    W'(BUSY),       W'(0));
        check("rst_done",    W'(FRAME_DONE), W'(0));
        INIT = 1'b1;

        // single frame with distinct per-channel probabilities
        exp_q.push_back(frame_sum(0, 1, 128, 255));
        do_load({8'd255, 8'd128, 8'd1, 8'd0});
        @(negedge CLK);
        check("lat_s_valid", W'(S_VALID), W'(0));
        check("lat_busy",    W'(BUSY),    W'(1));
        wait_idle();
        check("idle_ready", W'(LOAD_READY), W'(1));

        // back-to-back frames with backpressure on a third load
        base = frames_seen;
        exp_q.push_back(frame_sum(64, 64, 64, 64));
        do_load({4{8'd64}});
        exp_q.push_back(frame_sum(200, 200, 200, 200));
        do_load({4{8'd200}});
        @(negedge CLK);
        check("shadow_full_ready", W'(LOAD_READY), W'(0));
        exp_q.push_back(frame_sum(30, 30, 30, 30));
        do_load({4{8'd30}});
        check("third_after_swap", W'(frames_seen - base), W'(1));
        wait_idle();
        check("b2b_frames", W'(frames_seen - base), W'(3));

        // load landing exactly on the last cycle of a frame
        exp_q.push_back(frame_sum(10, 10, 10, 10));
        do_load({4{8'd10}});
        repeat (254) @(posedge CLK);
        exp_q.push_back(frame_sum(20, 20, 20, 20));
        do_load({4{8'd20}});
        check("boundary_ready", W'(LOAD_READY), W'(1));
        check("boundary_busy",  W'(BUSY),       W'(1));
        wait_idle();

        // STOP at cnt=100 with shadow full
        abort_ok = 1'b1;
        do_load({4{8'd50}});
        do_load({4{8'd60}});
        repeat (99) @(posedge CLK);
        @(negedge CLK);
        STOP = 1'b1;
        @(posedge CLK);
        #1;
        STOP = 1'b0;
        @(negedge CLK);
        check("stop_s_valid", W'(S_VALID),    W'(0));
        check("stop_ready",   W'(LOAD_READY), W'(1));
        check("stop_busy",    W'(BUSY),       W'(0));
        STOP       = 1'b1;
        LOAD_VALID = 1'b1;
        D_IN       = {4{8'd77}};
        @(posedge CLK);
        #1;
        STOP       = 1'b0;
        LOAD_VALID = 1'b0;
        check("stop_discards_load", W'(BUSY), W'(0));
        @(negedge CLK);
        abort_ok = 1'b0;
        exp_q.push_back(frame_sum(90, 90, 90, 90));
        do_load({4{8'd90}});
        wait_idle();

        // async reset at cnt=37
        do_load({4{8'd128}});
        repeat (37) @(posedge CLK);
        abort_ok = 1'b1;
        #2;
        INIT = 1'b0;
        #1;
        check("init_s",       W'(S),          W'(0));
        check("init_s_valid", W'(S_VALID),    W'(0));
        check("init_done",    W'(FRAME_DONE), W'(0));
        check("init_busy",    W'(BUSY),       W'(0));
        repeat (2) @(negedge CLK);
        INIT = 1'b1;
        abort_ok = 1'b0;
        exp_q.push_back(frame_sum(128, 128, 128, 128));
        do_load({4{8'd128}});
        wait_idle();

        repeat (3) @(negedge CLK);
        check("queue_empty", W'(exp_q.size()), W'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
